// File: rtl/z80_bus_master.sv
// z80_bus_master: turns a valid/ready command into Z80 memory or I/O bus cycles
// (T1, T2, TW, T3), each T-state split into an H and an L phase of HALF_DIV clocks.
// Optional feature macro: Z80M_WAIT_TIMEOUT_EN aborts a cycle after WAIT_MAX
// consecutive wait states and flags rsp_err.
module z80_bus_master #(
  parameter int unsigned HALF_DIV = 3,
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic        CLK_24MHz,
  input  logic        RES,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_io,
  input  logic        cmd_wr,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic [15:0] A,
  output logic [7:0]  D_out,
  output logic        D_oe,
  input  logic [7:0]  D_in,
  output logic        MREQ,
  output logic        IORQ,
  output logic        RD,
  output logic        WR,
  output logic        M1,
  input  logic        WAIT,
  output logic        CLK_OUT
);

  if (HALF_DIV < 1 || HALF_DIV > 15 || WAIT_MAX < 1) begin : g_param_check
    $error("z80_bus_master: HALF_DIV must be 1..15 and WAIT_MAX at least 1");
  end

  typedef enum logic [2:0] {StIdle, StT1, StT2, StTw, StT3} state_e;

  localparam logic [3:0] CntLast = 4'(HALF_DIV - 1);

  state_e      state_q, state_d;
  logic        phl_q, phl_d;      // 0 = H phase, 1 = L phase
  logic [3:0]  cnt_q, cnt_d;
  logic        io_q, io_d;
  logic        wr_q, wr_d;
  logic [15:0] a_q, a_d;
  logic [7:0]  dout_q, dout_d;
  logic        doe_q, doe_d;
  logic        wait_q, wait_d;    // last sampled WAIT, decides TW vs T3
  logic [7:0]  rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        half_end;

`ifdef Z80M_WAIT_TIMEOUT_EN
  localparam int unsigned WcW = $clog2(WAIT_MAX + 1);
  logic [WcW-1:0] wcnt_q, wcnt_d;
  logic           to_q, to_d;
  logic           rerr_q, rerr_d;
`endif

  // State and datapath registers, async active-low reset
  always_ff @(posedge CLK_24MHz or negedge RES) begin
    if (!RES) begin
      state_q  <= StIdle;
      phl_q    <= 1'b0;
      cnt_q    <= '0;
      io_q     <= 1'b0;
      wr_q     <= 1'b0;
      a_q      <= '0;
      dout_q   <= '0;
      doe_q    <= 1'b0;
      wait_q   <= 1'b1;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
`ifdef Z80M_WAIT_TIMEOUT_EN
      wcnt_q   <= '0;
      to_q     <= 1'b0;
      rerr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      phl_q    <= phl_d;
      cnt_q    <= cnt_d;
      io_q     <= io_d;
      wr_q     <= wr_d;
      a_q      <= a_d;
      dout_q   <= dout_d;
      doe_q    <= doe_d;
      wait_q   <= wait_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
`ifdef Z80M_WAIT_TIMEOUT_EN
      wcnt_q   <= wcnt_d;
      to_q     <= to_d;
      rerr_q   <= rerr_d;
`endif
    end
  end

  // Next-state: phase counter, T-state sequencing, wait sampling, data capture
  always_comb begin
    state_d  = state_q;
    phl_d    = phl_q;
    cnt_d    = cnt_q + 4'd1;
    io_d     = io_q;
    wr_d     = wr_q;
    a_d      = a_q;
    dout_d   = dout_q;
    doe_d    = doe_q;
    wait_d   = wait_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
`ifdef Z80M_WAIT_TIMEOUT_EN
    wcnt_d   = wcnt_q;
    to_d     = to_q;
    rerr_d   = 1'b0;
`endif
    half_end = (cnt_q == CntLast);
    if (half_end) begin
      cnt_d = '0;
      phl_d = ~phl_q;
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d = StT1;
          phl_d   = 1'b0;
          cnt_d   = '0;
          io_d    = cmd_io;
          wr_d    = cmd_wr;
          a_d     = cmd_addr;
          if (cmd_wr) begin
            dout_d = cmd_data;
            doe_d  = 1'b1;
          end
`ifdef Z80M_WAIT_TIMEOUT_EN
          wcnt_d = '0;
          to_d   = 1'b0;
`endif
        end
      end
      StT1: begin
        if (half_end && phl_q) state_d = StT2;
      end
      StT2: begin
        // Memory cycles sample WAIT entering T2L; I/O always takes one TW
        if (half_end && !phl_q && !io_q) wait_d = WAIT;
        if (half_end && phl_q) state_d = (io_q || !wait_q) ? StTw : StT3;
      end
      StTw: begin
        if (half_end && !phl_q) begin
          wait_d = WAIT;
`ifdef Z80M_WAIT_TIMEOUT_EN
          if (!WAIT) wcnt_d = wcnt_q + 1'b1;
`endif
        end
        if (half_end && phl_q) begin
          if (wait_q) state_d = StT3;
`ifdef Z80M_WAIT_TIMEOUT_EN
          if (!wait_q && (wcnt_q >= WcW'(WAIT_MAX))) begin
            state_d = StT3;
            to_d    = 1'b1;
          end
`endif
        end
      end
      StT3: begin
        if (half_end && phl_q) begin
          state_d  = StIdle;
          doe_d    = 1'b0;
          rvalid_d = 1'b1;
`ifdef Z80M_WAIT_TIMEOUT_EN
          rerr_d   = to_q;
`endif
        end
      end
      default: state_d = StIdle;
    endcase

    // Read data is captured on the edge that enters T3H
    if ((state_q == StT2 || state_q == StTw) && state_d == StT3 && !wr_q) rdata_d = D_in;
  end

  // Outputs: strobe windows decoded from state and phase
  always_comb begin
    logic mem_win, io_win, wr_win;
    mem_win   = (state_q == StT1 && phl_q) || state_q == StT2 || state_q == StTw ||
                (state_q == StT3 && !phl_q);
    io_win    = state_q == StT2 || state_q == StTw || (state_q == StT3 && !phl_q);
    wr_win    = (state_q == StT2 && phl_q) || state_q == StTw || (state_q == StT3 && !phl_q);
    MREQ      = ~(!io_q && mem_win);
    IORQ      = ~(io_q && io_win);
    RD        = ~(!wr_q && (io_q ? io_win : mem_win));
    WR        = ~(wr_q && (io_q ? io_win : wr_win));
    M1        = 1'b1;
    CLK_OUT   = ~phl_q;
    cmd_ready = (state_q == StIdle);
    A         = a_q;
    D_out     = dout_q;
    D_oe      = doe_q;
    rsp_valid = rvalid_q;
    rsp_data  = rdata_q;
`ifdef Z80M_WAIT_TIMEOUT_EN
    rsp_err   = rerr_q;
`else
    rsp_err   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_z80_bus_master.sv
// Directed bench for z80_bus_master at HALF_DIV = 3, WAIT_MAX = 4.
module tb_z80_bus_master;

  localparam int HD = 3;
  localparam int WM = 4;

  logic        CLK_24MHz = 1'b0;
  logic        RES;
  logic        cmd_valid, cmd_ready, cmd_io, cmd_wr;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_data;
  logic [15:0] A;
  logic [7:0]  D_out, D_in;
  logic        D_oe, MREQ, IORQ, RD, WR, M1, WAIT, CLK_OUT;

  int n_pass = 0;
  int n_total = 0;

  z80_bus_master #(.HALF_DIV(HD), .WAIT_MAX(WM)) dut (
    .CLK_24MHz(CLK_24MHz), .RES(RES),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_io(cmd_io), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .A(A), .D_out(D_out), .D_oe(D_oe), .D_in(D_in),
    .MREQ(MREQ), .IORQ(IORQ), .RD(RD), .WR(WR), .M1(M1),
    .WAIT(WAIT), .CLK_OUT(CLK_OUT)
  );

  always #5 CLK_24MHz = ~CLK_24MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command and watch it to rsp_valid. lat is the number of clock edges
  // from the accept edge to the first cycle with rsp_valid high (-1 if never seen).
  // WAIT starts at wait_init and is raised when the cycle index reaches rel_j.
  task automatic run_cycle(input logic io, input logic wr, input logic [15:0] addr,
                           input logic [7:0] data, input logic wait_init, input int rel_j,
                           input int limit, output int lat, output int n_iorq,
                           output int n_mreq, output int n_rd, output int n_wr,
                           output int n_rdy, output logic [15:0] a_s,
                           output logic [7:0] d_s, output logic oe_s, output logic err);
    int j;
    WAIT = wait_init;
    cmd_io = io; cmd_wr = wr; cmd_addr = addr; cmd_data = data;
    cmd_valid = 1'b1;
    @(posedge CLK_24MHz); #1;
    cmd_valid = 1'b0;
    lat = -1; n_iorq = 0; n_mreq = 0; n_rd = 0; n_wr = 0; n_rdy = 0;
    a_s = 'x; d_s = 'x; oe_s = 1'bx; err = 1'bx;
    j = 0;
    while (j <= limit) begin
      if (rsp_valid) begin
        lat = j;
        err = rsp_err;
        break;
      end
      if (!IORQ) n_iorq++;
      if (!MREQ) n_mreq++;
      if (!RD) n_rd++;
      if (!WR) n_wr++;
      if (cmd_ready) n_rdy++;
      if (j == 2 * HD) begin
        a_s = A; d_s = D_out; oe_s = D_oe;
      end
      if (j == rel_j) WAIT = 1'b1;
      @(posedge CLK_24MHz); #1;
      j++;
    end
    WAIT = 1'b1;
  endtask

  initial begin
    int lat, ni, nm, nr, nw, nrdy, nrsp;
    logic [15:0] a_s;
    logic [7:0]  d_s;
    logic        oe_s, err;

    RES = 1'b0; cmd_valid = 1'b0; cmd_io = 1'b0; cmd_wr = 1'b0;
    cmd_addr = '0; cmd_data = '0; D_in = '0; WAIT = 1'b1;
    repeat (3) @(posedge CLK_24MHz);
    #1;
    chk("rst_A", 32'(A), 32'h0);
    chk("rst_strobes", 32'({MREQ, IORQ, RD, WR, M1}), 32'h1f);
    chk("rst_doe", 32'(D_oe), 32'h0);
    chk("rst_dout", 32'(D_out), 32'h0);
    chk("rst_clkout", 32'(CLK_OUT), 32'h1);
    chk("rst_ready", 32'(cmd_ready), 32'h1);
    chk("rst_rsp", 32'({rsp_valid, rsp_err}), 32'h0);
    chk("rst_rdata", 32'(rsp_data), 32'h0);
    RES = 1'b1;
    repeat (2) @(posedge CLK_24MHz);
    #1;

    // I/O write 0x0010 <- 0x11
    run_cycle(1'b1, 1'b1, 16'h0010, 8'h11, 1'b1, -1, 100,
              lat, ni, nm, nr, nw, nrdy, a_s, d_s, oe_s, err);
    chk("iow1_lat", 32'(lat), 32'd24);
    chk("iow1_iorq", 32'(ni), 32'd15);
    chk("iow1_wr", 32'(nw), 32'd15);
    chk("iow1_mreq_rd", 32'(nm + nr), 32'd0);
    chk("iow1_ready_busy", 32'(nrdy), 32'd0);
    chk("iow1_addr", 32'(a_s), 32'h0010);
    chk("iow1_dout", 32'(d_s), 32'h11);
    chk("iow1_doe", 32'(oe_s), 32'h1);
    chk("iow1_err", 32'(err), 32'h0);
    chk("iow1_A_hold", 32'(A), 32'h0010);

    // Back-to-back I/O write 0x0011 <- 0x01
    run_cycle(1'b1, 1'b1, 16'h0011, 8'h01, 1'b1, -1, 100,
              lat, ni, nm, nr, nw, nrdy, a_s, d_s, oe_s, err);
    chk("iow2_lat", 32'(lat), 32'd24);
    chk("iow2_iorq", 32'(ni), 32'd15);
    chk("iow2_ready_busy", 32'(nrdy), 32'd0);
    chk("iow2_addr", 32'(a_s), 32'h0011);
    chk("iow2_dout", 32'(d_s), 32'h01);
    @(posedge CLK_24MHz); #1;
    chk("iow2_rsp_pulse", 32'(rsp_valid), 32'h0);
    chk("iow2_doe_off", 32'(D_oe), 32'h0);

    // Memory read 0x4000, data 0xA5
    D_in = 8'hA5;
    run_cycle(1'b0, 1'b0, 16'h4000, 8'h00, 1'b1, -1, 100,
              lat, ni, nm, nr, nw, nrdy, a_s, d_s, oe_s, err);
    chk("mrd_lat", 32'(lat), 32'd18);
    chk("mrd_mreq", 32'(nm), 32'd12);
    chk("mrd_rd", 32'(nr), 32'd12);
    chk("mrd_iorq_wr", 32'(ni + nw), 32'd0);
    chk("mrd_addr", 32'(a_s), 32'h4000);
    chk("mrd_data", 32'(rsp_data), 32'hA5);
    @(posedge CLK_24MHz); #1;

    // Memory read with two wait samples low
    D_in = 8'h5A;
    run_cycle(1'b0, 1'b0, 16'h4001, 8'h00, 1'b0, 18, 100,
              lat, ni, nm, nr, nw, nrdy, a_s, d_s, oe_s, err);
    chk("mwait_lat", 32'(lat), 32'd30);
    chk("mwait_mreq", 32'(nm), 32'd24);
    chk("mwait_data", 32'(rsp_data), 32'h5A);
    @(posedge CLK_24MHz); #1;

    // Memory write 0x8000 <- 0x77; read data register must not change
    D_in = 8'hC3;
    run_cycle(1'b0, 1'b1, 16'h8000, 8'h77, 1'b1, -1, 100,
              lat, ni, nm, nr, nw, nrdy, a_s, d_s, oe_s, err);
    chk("mwr_lat", 32'(lat), 32'd18);
    chk("mwr_wr", 32'(nw), 32'd6);
    chk("mwr_mreq", 32'(nm), 32'd12);
    chk("mwr_rd", 32'(nr), 32'd0);
    chk("mwr_dout", 32'(d_s), 32'h77);
    chk("mwr_rdata_hold", 32'(rsp_data), 32'h5A);
    @(posedge CLK_24MHz); #1;

    // Reset during T2 of an I/O write
    cmd_io = 1'b1; cmd_wr = 1'b1; cmd_addr = 16'h0012; cmd_data = 8'h22;
    cmd_valid = 1'b1;
    @(posedge CLK_24MHz); #1;
    cmd_valid = 1'b0;
    repeat (7) begin
      @(posedge CLK_24MHz); #1;
    end
    chk("midrst_iorq_before", 32'(IORQ), 32'h0);
    RES = 1'b0;
    #1;
    chk("midrst_strobes", 32'({MREQ, IORQ, RD, WR, M1}), 32'h1f);
    chk("midrst_doe", 32'(D_oe), 32'h0);
    chk("midrst_A", 32'(A), 32'h0);
    #1;
    RES = 1'b1;
    nrsp = 0;
    repeat (50) begin
      @(posedge CLK_24MHz); #1;
      if (rsp_valid) nrsp++;
    end
    chk("midrst_no_rsp", 32'(nrsp), 32'd0);
    chk("midrst_ready", 32'(cmd_ready), 32'h1);

    // I/O read with WAIT stuck low
    D_in = 8'h3C;
`ifdef Z80M_WAIT_TIMEOUT_EN
    run_cycle(1'b1, 1'b0, 16'h0020, 8'h00, 1'b0, -1, 200,
              lat, ni, nm, nr, nw, nrdy, a_s, d_s, oe_s, err);
    chk("tmo_lat", 32'(lat), 32'd42);
    chk("tmo_err", 32'(err), 32'h1);
    chk("tmo_iorq", 32'(ni), 32'd33);
    chk("tmo_data", 32'(rsp_data), 32'h3C);
`else
    run_cycle(1'b1, 1'b0, 16'h0020, 8'h00, 1'b0, -1, 1000,
              lat, ni, nm, nr, nw, nrdy, a_s, d_s, oe_s, err);
    chk("stuck_no_rsp", 32'(lat), 32'hffff_ffff);
    chk("stuck_iorq_low", 32'(IORQ), 32'h0);
    RES = 1'b0;
    #2;
    RES = 1'b1;
    @(posedge CLK_24MHz); #1;
    chk("stuck_ready_after_rst", 32'(cmd_ready), 32'h1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
